// File: rtl/timer_counter.sv
// Programmable up-counter feeding the timer compare stage: prescaled counting,
// one-shot/periodic modes, pause/resume and a registered end-of-period pulse.
module timer_counter #(
    parameter int word_size  = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  newclk_k,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [word_size-1:0]  period_in,
    input  logic                  clr_n,
    output logic [word_size-1:0]  timer_in,
    output logic [word_size-1:0]  out,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [word_size-1:0]    timer_n, out_n;
    logic [PRESCALE_W-1:0]   pre_cnt, pre_n;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_n;
    logic                    mode_q, mode_n;
    logic                    done_n;
    logic                    at_top, tick, period_end;

    assign at_top     = (timer_in == out);
    assign tick       = (pre_cnt == prescale_q);
    // The comparator's clear lags by one clock, so it only counts once the
    // count is actually sitting on the compare value.
    assign period_end = (state == S_RUN) && !clr_n && at_top;

    assign busy      = (state == S_RUN) || (state == S_PAUSE);
    assign state_dbg = state;

    always_ff @(posedge newclk_k or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer_in   <= '0;
            out        <= {word_size{1'b1}};
            pre_cnt    <= '0;
            prescale_q <= '0;
            mode_q     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            timer_in   <= timer_n;
            out        <= out_n;
            pre_cnt    <= pre_n;
            prescale_q <= prescale_n;
            mode_q     <= mode_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer_in;
        out_n      = out;
        pre_n      = pre_cnt;
        prescale_n = prescale_q;
        mode_n     = mode_q;
        done_n     = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (load) begin
                    out_n = period_in;
                end
                if (start) begin
                    state_n    = S_RUN;
                    timer_n    = '0;
                    pre_n      = '0;
                    mode_n     = mode;
                    prescale_n = prescale;
                end
            end
            S_RUN: begin
                if (period_end) begin
                    timer_n = '0;
                    pre_n   = '0;
                    done_n  = 1'b1;
                    state_n = mode_q ? S_RUN : S_DONE;
                end else if (stop) begin
                    state_n = S_PAUSE;
                end else begin
                    pre_n = tick ? '0 : pre_cnt + 1'b1;
                    // Saturate at the compare value; the comparator ends the period.
                    if (tick && !at_top) begin
                        timer_n = timer_in + 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (start) begin
                    state_n = S_RUN;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
